nf1g_pbs_rr_arbiter: RTL and testbench
======================================

Name: nf1g_pbs_rr_arbiter

Overview:
- Shares the single NetFPGA-1G packet bus feeding the NIC port's output-port-lookup stage between NUM_QUEUES upstream requesters (MAC/CPU RX queues).
- Each requester has a small input FIFO. A packet-granular round-robin scheduler drains one whole packet at a time onto the shared M_PBS bus.
- Uses the same DATA/CTRL/WR/RDY handshake on both sides, so it drops in directly upstream of the NIC port.

Parameters:
- C_PBS_DATA_WIDTH, 64, data width per queue and for the output; CTRL width is C_PBS_DATA_WIDTH/8.
- NUM_QUEUES, 4, number of requesters (2..8).
- QUEUE_SEL_WIDTH, 2, ceil(log2(NUM_QUEUES)).
- FIFO_DEPTH_BITS, 3, per-queue FIFO depth = 2^FIFO_DEPTH_BITS words.

Ports:
- CLK  in  1  single clock.
- RESET  in  1  synchronous, active-high reset.
- S_PBS_DATA  in  NUM_QUEUES*C_PBS_DATA_WIDTH  flattened input data; queue i occupies slice [i*W +: W].
- S_PBS_CTRL  in  NUM_QUEUES*C_PBS_DATA_WIDTH/8  flattened input ctrl.
- S_PBS_WR  in  NUM_QUEUES  per-queue write strobe.
- S_PBS_RDY  out  NUM_QUEUES  per-queue ready.
- M_PBS_DATA  out  C_PBS_DATA_WIDTH  arbitrated data.
- M_PBS_CTRL  out  C_PBS_DATA_WIDTH/8  arbitrated ctrl.
- M_PBS_WR  out  1  output write strobe.
- M_PBS_RDY  in  1  downstream ready.
- ARB_GRANT  out  QUEUE_SEL_WIDTH  currently granted queue (debug).
- ARB_ACTIVE  out  1  high while a packet is being forwarded (debug).

Behaviour:
- Reset (synchronous, all state): M_PBS_WR=0, M_PBS_DATA=0, M_PBS_CTRL=0, S_PBS_RDY=0, ARB_GRANT=0, ARB_ACTIVE=0, rr pointer=0, all FIFOs empty, in_payload=0. S_PBS_RDY returns high the first cycle after RESET deasserts.
- Input FIFO i:
  - Write when S_PBS_WR[i]=1.
  - S_PBS_RDY[i] is registered and high when count <= depth-2, giving one word of slack for the registered ready.
  - A write while full is ignored; the count does not change.
  - A push and a pop in the same cycle leave the count unchanged; a push into an empty FIFO is poppable the next cycle.
- Packet framing:
  - A word with ctrl!=0 seen while in_payload=0 is a header; it does not end the packet.
  - A word with ctrl==0 sets in_payload=1.
  - A word with ctrl!=0 seen while in_payload=1 is EOP; it clears in_payload.
- FSM states:
  - IDLE:
    - Scan queues in order ptr, ptr+1, ... (mod NUM_QUEUES); the first non-empty queue wins.
    - Register ARB_GRANT; go to SEND. No pop happens in IDLE.
    - If all queues are empty, stay in IDLE.
  - SEND:
    - ARB_ACTIVE=1.
    - Each cycle with M_PBS_RDY=1 and FIFO[grant] non-empty: pop one word and register it to M_PBS_DATA/CTRL; M_PBS_WR=1 on the next cycle. Otherwise M_PBS_WR=0 next cycle and DATA/CTRL hold.
    - On popping the EOP word: ptr = (grant+1) mod NUM_QUEUES; go to IDLE.
    - The grant is held across mid-packet starvation (FIFO empty) for any duration. No other queue is interleaved.
- Latency:
  - From IDLE, a head word appears on M_PBS_WR 2 cycles after it becomes poppable (grant cycle + output register).
  - In SEND, 1 cycle per word.
  - Exactly one bubble cycle occurs between consecutive packets.
- M_PBS_RDY=0 for any duration: no pop occurs, and no word is lost or duplicated.
- Fairness: a queue that is continuously non-empty is served within NUM_QUEUES-1 packets of other queues.
- RESET asserted mid-packet: the partial packet is discarded and the FSM returns to IDLE. Downstream handles the truncated packet.

Decomposition:
- Package nf1g_pbs_pkg holds:
  - FSM state encoding constants ST_IDLE=0, ST_SEND=1;
  - ctrl helper constant CTRL_DATA_WORD=0.
- Sub-module pbs_small_fifo:
  - parameters WIDTH, DEPTH_BITS;
  - ports: synchronous RESET, wr_en, din, rd_en, dout (registered head), empty, full, nearly_full.
  - Instantiated NUM_QUEUES times with WIDTH = data+ctrl.

Test Plan:
- Single packet on queue 2: ctrl 0xFF, 0x00, 0x00, 0x04 with data 0x1..0x4. Expect the same 4 words on M_PBS with WR=1 on consecutive cycles, the first 2 cycles after the FIFO becomes non-empty, and ARB_GRANT=2.
- All 4 queues hold 2 packets each from t=0. Expect output packet order q0,q1,q2,q3,q0,q1,q2,q3 with no word interleaving and one bubble between packets.
- M_PBS_RDY=0 for 5 cycles in the middle of a 6-word packet. Expect M_PBS_WR=0 and DATA held during the stall, then all 6 words in order with none lost or duplicated.
- Queue 1 writes 8 words with M_PBS_RDY=0 and FIFO_DEPTH_BITS=3. Expect S_PBS_RDY[1] to drop once count reaches 7; the 9th attempted write is ignored.
- Queue 0 stalls mid-packet for 10 cycles while queue 3 has a full packet waiting. Expect ARB_GRANT to stay 0 until queue 0's EOP, then switch to 3.
- RESET pulsed for 1 cycle mid-packet. Expect M_PBS_WR=0 and DATA=0 next cycle, S_PBS_RDY all 0 during reset then all 1, ptr=0, and a fresh packet on queue 3 forwarded normally afterward.

Source files
------------

// File: rtl/nf1g_pbs_pkg.sv
// nf1g_pbs_pkg: shared FSM state encoding and ctrl constants for the PBS round-robin arbiter
package nf1g_pbs_pkg;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } arb_state_t;
    localparam int CTRL_DATA_WORD = 0;
endpackage

// File: rtl/pbs_small_fifo.sv
// pbs_small_fifo: small per-requester word FIFO with a register-array head and occupancy flags
// Ports: CLK/RESET (sync, active-high); wr_en/din push; rd_en/dout pop and current head;
//        empty, full (2^DEPTH_BITS words), nearly_full (one free slot or fewer).
module pbs_small_fifo #(
    parameter int WIDTH      = 72,
    parameter int DEPTH_BITS = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             nearly_full
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int CW    = DEPTH_BITS + 1;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic                  push;
    logic                  pop;
    assign push        = wr_en && !full;
    assign pop         = rd_en && !empty;
    assign empty       = count == '0;
    assign full        = count == CW'(DEPTH);
    assign nearly_full = count >= CW'(DEPTH - 1);
    assign dout        = mem[rd_ptr];
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
            if (pop) rd_ptr <= rd_ptr + DEPTH_BITS'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/nf1g_pbs_rr_arbiter.sv
// nf1g_pbs_rr_arbiter: packet-granular round-robin merge of NUM_QUEUES PBS streams onto one PBS bus
// Ports: CLK/RESET (sync, active-high); S_PBS_* flattened per-queue inputs with registered RDY;
//        M_PBS_* arbitrated output; ARB_GRANT/ARB_ACTIVE debug view of the scheduler.
module nf1g_pbs_rr_arbiter
    import nf1g_pbs_pkg::*;
#(
    parameter int C_PBS_DATA_WIDTH = 64,
    parameter int NUM_QUEUES       = 4,
    parameter int QUEUE_SEL_WIDTH  = 2,
    parameter int FIFO_DEPTH_BITS  = 3
) (
    input  logic                                        CLK,
    input  logic                                        RESET,
    input  logic [NUM_QUEUES*C_PBS_DATA_WIDTH-1:0]      S_PBS_DATA,
    input  logic [NUM_QUEUES*C_PBS_DATA_WIDTH/8-1:0]    S_PBS_CTRL,
    input  logic [NUM_QUEUES-1:0]                       S_PBS_WR,
    output logic [NUM_QUEUES-1:0]                       S_PBS_RDY,
    output logic [C_PBS_DATA_WIDTH-1:0]                 M_PBS_DATA,
    output logic [C_PBS_DATA_WIDTH/8-1:0]               M_PBS_CTRL,
    output logic                                        M_PBS_WR,
    input  logic                                        M_PBS_RDY,
    output logic [QUEUE_SEL_WIDTH-1:0]                  ARB_GRANT,
    output logic                                        ARB_ACTIVE
);
    localparam int DW = C_PBS_DATA_WIDTH;
    localparam int CW = DW / 8;
    localparam int FW = DW + CW;
    logic [FW-1:0]              head [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]      empty;
    logic [NUM_QUEUES-1:0]      full;
    logic [NUM_QUEUES-1:0]      nearly_full;
    arb_state_t                 state;
    arb_state_t                 state_next;
    logic [QUEUE_SEL_WIDTH-1:0] ptr;
    logic [QUEUE_SEL_WIDTH-1:0] pick;
    logic [QUEUE_SEL_WIDTH-1:0] idx;
    logic                       found;
    logic                       pop;
    logic                       eop;
    logic                       is_data;
    logic                       in_payload;
    logic [FW-1:0]              word;

    for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_q
        pbs_small_fifo #(.WIDTH(FW), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo (
            .CLK         (CLK),
            .RESET       (RESET),
            .wr_en       (S_PBS_WR[i] && !full[i]),
            .din         ({S_PBS_CTRL[i*CW +: CW], S_PBS_DATA[i*DW +: DW]}),
            .rd_en       (pop && ARB_GRANT == QUEUE_SEL_WIDTH'(i)),
            .dout        (head[i]),
            .empty       (empty[i]),
            .full        (full[i]),
            .nearly_full (nearly_full[i])
        );
    end

    assign ARB_ACTIVE = state == ST_SEND;

    // Highest-priority candidate is ptr itself, so scan backwards and let later hits override.
    always_comb begin
        pick  = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
            idx = QUEUE_SEL_WIDTH'((int'(ptr) + k) % NUM_QUEUES);
            if (!empty[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        word       = head[ARB_GRANT];
        is_data    = word[FW-1 -: CW] == CW'(CTRL_DATA_WORD);
        pop        = state == ST_SEND && M_PBS_RDY && !empty[ARB_GRANT];
        eop        = pop && in_payload && !is_data;
        state_next = state == ST_IDLE ? (found ? ST_SEND : ST_IDLE) : (eop ? ST_IDLE : ST_SEND);
    end

    always_ff @(posedge CLK) begin
        state <= RESET ? ST_IDLE : state_next;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr        <= '0;
            ARB_GRANT  <= '0;
            in_payload <= 1'b0;
            M_PBS_WR   <= 1'b0;
            M_PBS_DATA <= '0;
            M_PBS_CTRL <= '0;
            S_PBS_RDY  <= '0;
        end else begin
            S_PBS_RDY <= ~nearly_full;
            M_PBS_WR  <= pop;
            if (state == ST_IDLE && found) ARB_GRANT <= pick;
            if (pop) begin
                {M_PBS_CTRL, M_PBS_DATA} <= word;
                in_payload               <= is_data;
            end
            if (eop) ptr <= ARB_GRANT == QUEUE_SEL_WIDTH'(NUM_QUEUES - 1) ? '0 : ARB_GRANT + QUEUE_SEL_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_nf1g_pbs_rr_arbiter.sv
// tb_nf1g_pbs_rr_arbiter: scoreboard bench with per-queue expected word queues and a packet log
module tb_nf1g_pbs_rr_arbiter;
    localparam int NQ = 4;
    typedef struct packed { logic [63:0] d; logic [7:0] c; logic eop; } word_t;
    typedef struct packed { int q; int start; int stop; int len; } pkt_t;

    logic           CLK = 1'b0;
    logic           RESET = 1'b1;
    logic [255:0]   S_PBS_DATA = '0;
    logic [31:0]    S_PBS_CTRL = '0;
    logic [3:0]     S_PBS_WR = '0;
    logic [3:0]     S_PBS_RDY;
    logic [63:0]    M_PBS_DATA;
    logic [7:0]     M_PBS_CTRL;
    logic           M_PBS_WR;
    logic           M_PBS_RDY = 1'b1;
    logic [1:0]     ARB_GRANT;
    logic           ARB_ACTIVE;

    nf1g_pbs_rr_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .S_PBS_DATA(S_PBS_DATA), .S_PBS_CTRL(S_PBS_CTRL), .S_PBS_WR(S_PBS_WR), .S_PBS_RDY(S_PBS_RDY),
        .M_PBS_DATA(M_PBS_DATA), .M_PBS_CTRL(M_PBS_CTRL), .M_PBS_WR(M_PBS_WR), .M_PBS_RDY(M_PBS_RDY),
        .ARB_GRANT(ARB_GRANT), .ARB_ACTIVE(ARB_ACTIVE)
    );

    always #5 CLK = ~CLK;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    word_t exp_q [NQ][$];
    word_t src_q [NQ][$];
    pkt_t  log_q [$];
    int    seq = 0;

    function automatic word_t mk(input int q, input int idx, input int len);
        word_t w;
        seq++;
        w.d   = {8'(q), 56'(seq)};
        w.c   = idx == 0 ? 8'hFF : (idx == len - 1 ? 8'h04 : 8'h00);
        w.eop = idx == len - 1;
        return w;
    endfunction

    function automatic int pending();
        int n = 0;
        for (int q = 0; q < NQ; q++) n += exp_q[q].size();
        return n;
    endfunction

    // Monitor: every output word must be the oldest outstanding word of the granted queue.
    logic        in_pkt = 1'b0;
    int          cur_q, cur_start, cur_len, mon_g;
    word_t       mon_w;
    logic [63:0] last_exp_d = '0;
    always @(negedge CLK) begin
        if (RESET) in_pkt = 1'b0;
        else if (M_PBS_WR) begin
            mon_g = int'(ARB_GRANT);
            if (exp_q[mon_g].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word q=%0d got=%0h want=none", mon_g, M_PBS_DATA);
            end else begin
                mon_w = exp_q[mon_g].pop_front();
                check("out_word", {M_PBS_CTRL, M_PBS_DATA}, {mon_w.c, mon_w.d});
                if (in_pkt && mon_g != cur_q) check("interleave", mon_g, cur_q);
                if (!in_pkt) begin
                    in_pkt    = 1'b1;
                    cur_q     = mon_g;
                    cur_start = cyc;
                    cur_len   = 0;
                end
                cur_len++;
                last_exp_d = mon_w.d;
                if (mon_w.eop) begin
                    log_q.push_back(pkt_t'{cur_q, cur_start, cyc, cur_len});
                    in_pkt = 1'b0;
                end
            end
        end
    end

    word_t        stg_w [NQ];
    logic [NQ-1:0] stg_wr = '0;
    logic [NQ-1:0] stg_keep = '0;
    int           last_acc = 0;

    task automatic stage(input int q, input word_t w, input logic keep);
        stg_w[q]    = w;
        stg_wr[q]   = 1'b1;
        stg_keep[q] = keep;
    endtask

    task automatic do_cycle();
        for (int q = 0; q < NQ; q++) begin
            S_PBS_DATA[q*64 +: 64] = stg_w[q].d;
            S_PBS_CTRL[q*8 +: 8]   = stg_w[q].c;
        end
        S_PBS_WR = stg_wr;
        @(posedge CLK);
        #1;
        last_acc = cyc;
        for (int q = 0; q < NQ; q++) if (stg_wr[q] && stg_keep[q]) exp_q[q].push_back(stg_w[q]);
        stg_wr   = '0;
        S_PBS_WR = '0;
    endtask

    task automatic do_reset();
        RESET    = 1'b1;
        stg_wr   = '0;
        S_PBS_WR = '0;
        @(posedge CLK);
        #1;
        for (int q = 0; q < NQ; q++) exp_q[q].delete();
        log_q.delete();
        check("rst_wr", M_PBS_WR, 0);
        check("rst_data", {M_PBS_CTRL, M_PBS_DATA}, 0);
        check("rst_rdy", S_PBS_RDY, 0);
        check("rst_grant", ARB_GRANT, 0);
        check("rst_active", ARB_ACTIVE, 0);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        check("rdy_after_rst", S_PBS_RDY, 4'hF);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        M_PBS_RDY = 1'b1;
        while (pending() != 0 || in_pkt) begin
            if (n >= budget) begin
                check("drain_timeout", pending(), 0);
                break;
            end
            do_cycle();
            n++;
        end
        repeat (6) do_cycle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        word_t w;
        repeat (2) @(posedge CLK);
        #1;

        // Single packet on queue 2
        do_reset();
        for (int i = 0; i < 4; i++) begin
            w.d   = 64'(i + 1);
            w.c   = i == 0 ? 8'hFF : (i == 3 ? 8'h04 : 8'h00);
            w.eop = i == 3;
            stage(2, w, 1'b1);
            do_cycle();
            if (i == 0) acc0 = last_acc;
        end
        drain(100);
        check("t1_npkt", log_q.size(), 1);
        if (log_q.size() > 0) begin
            check("t1_grant", log_q[0].q, 2);
            check("t1_len", log_q[0].len, 4);
            check("t1_latency", log_q[0].start, acc0 + 2);
            check("t1_back2back", log_q[0].stop - log_q[0].start, 3);
        end

        // Two packets per queue preloaded: strict rotation with one bubble
        do_reset();
        M_PBS_RDY = 1'b0;
        for (int i = 0; i < 6; i++) begin
            for (int q = 0; q < NQ; q++) stage(q, mk(q, i % 3, 3), 1'b1);
            do_cycle();
        end
        drain(200);
        check("t2_npkt", log_q.size(), 8);
        for (int i = 0; i < log_q.size() && i < 8; i++) begin
            check("t2_order", log_q[i].q, i % 4);
            check("t2_len", log_q[i].len, 3);
            if (i > 0) check("t2_bubble", log_q[i].start, log_q[i-1].stop + 2);
        end

        // Downstream stall in the middle of a 6-word packet
        do_reset();
        M_PBS_RDY = 1'b0;
        for (int i = 0; i < 6; i++) begin
            stage(0, mk(0, i, 6), 1'b1);
            do_cycle();
        end
        M_PBS_RDY = 1'b1;
        repeat (3) do_cycle();
        M_PBS_RDY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_cycle();
            check("t3_stall_wr", M_PBS_WR, 0);
            check("t3_stall_hold", M_PBS_DATA, last_exp_d);
        end
        drain(100);
        check("t3_npkt", log_q.size(), 1);
        if (log_q.size() > 0) check("t3_len", log_q[0].len, 6);

        // Fill queue 1 past capacity with the output blocked
        do_reset();
        M_PBS_RDY = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            stage(1, k <= 8 ? mk(1, k - 1, 8) : mk(1, 0, 3), k <= 8);
            do_cycle();
            check("t4_rdy", S_PBS_RDY[1], (k - 1) <= 6);
        end
        drain(100);
        check("t4_npkt", log_q.size(), 1);
        if (log_q.size() > 0) check("t4_len", log_q[0].len, 8);
        check("t4_rdy_back", S_PBS_RDY[1], 1);

        // Grant held across a starved queue 0 while queue 3 waits
        do_reset();
        stage(0, mk(0, 0, 4), 1'b1);
        stage(3, mk(3, 0, 3), 1'b1);
        do_cycle();
        stage(0, mk(0, 1, 4), 1'b1);
        stage(3, mk(3, 1, 3), 1'b1);
        do_cycle();
        stage(3, mk(3, 2, 3), 1'b1);
        do_cycle();
        for (int i = 0; i < 10; i++) begin
            do_cycle();
            check("t5_hold_grant", ARB_GRANT, 0);
            check("t5_active", ARB_ACTIVE, 1);
        end
        stage(0, mk(0, 2, 4), 1'b1);
        do_cycle();
        stage(0, mk(0, 3, 4), 1'b1);
        do_cycle();
        drain(100);
        check("t5_npkt", log_q.size(), 2);
        if (log_q.size() > 1) begin
            check("t5_first", log_q[0].q, 0);
            check("t5_first_len", log_q[0].len, 4);
            check("t5_second", log_q[1].q, 3);
        end

        // Reset pulse mid-packet; rotation pointer must restart at 0
        do_reset();
        for (int i = 0; i < 3; i++) begin
            stage(2, mk(2, i, 3), 1'b1);
            do_cycle();
        end
        drain(100);
        for (int i = 0; i < 6; i++) begin
            stage(1, mk(1, i, 6), 1'b1);
            do_cycle();
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            stage(3, mk(3, i, 3), 1'b1);
            stage(2, mk(2, i, 3), 1'b1);
            do_cycle();
        end
        drain(100);
        check("t6_npkt", log_q.size(), 2);
        if (log_q.size() > 1) begin
            check("t6_first", log_q[0].q, 2);
            check("t6_second", log_q[1].q, 3);
            check("t6_second_len", log_q[1].len, 3);
        end

        // Random traffic on all queues with random backpressure
        do_reset();
        for (int q = 0; q < NQ; q++)
            for (int p = 0; p < 5; p++) begin
                int len = $urandom_range(3, 7);
                for (int i = 0; i < len; i++) begin
                    w = mk(q, i, len);
                    if (i == 0) w.c = 8'($urandom_range(1, 255));
                    if (i == len - 1) w.c = 8'($urandom_range(1, 255));
                    src_q[q].push_back(w);
                end
            end
        for (int n = 0; n < 4000; n++) begin
            int left = 0;
            for (int q = 0; q < NQ; q++) left += src_q[q].size();
            if (left == 0) break;
            M_PBS_RDY = ($urandom % 4) != 0;
            for (int q = 0; q < NQ; q++)
                if (src_q[q].size() != 0 && S_PBS_RDY[q] && ($urandom % 2) == 1) stage(q, src_q[q].pop_front(), 1'b1);
            do_cycle();
        end
        drain(2000);
        check("t7_npkt", log_q.size(), 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
